// File: rtl/businv_pkg.sv
// Shared defaults, link word layout and popcount helper for the bus-invert link.
package businv_pkg;

   localparam int unsigned W_DEF    = 8;
   localparam int unsigned NREQ_DEF = 4;
   localparam int unsigned CNTW_DEF = 16;
   localparam int unsigned PC_MAXW  = 64;

   typedef struct packed {
      logic              inv;
      logic [W_DEF-1:0]  data;
   } link_t;

   // Callers zero-extend narrower vectors into the fixed-width argument.
   function automatic int unsigned popcount(input logic [PC_MAXW-1:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < PC_MAXW; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/businv_encode.sv
// Combinational bus-invert encoder: picks the link word for d given the
// current link word p, and reports how many link bits that word toggles.
module businv_encode
   import businv_pkg::*;
#(
   parameter int unsigned W  = W_DEF,
   parameter int unsigned TW = $clog2(W + 2)
) (
   input  logic [W-1:0]  d_i,
   input  logic [W:0]    p_i,
   input  logic          cfg_en_i,
   output logic [W:0]    enc_o,
   output logic [TW-1:0] tog_o
);

   logic [PC_MAXW-1:0] diff_data;
   logic [PC_MAXW-1:0] diff_link;
   logic               inv;

   // Invert decision uses data lines only; the toggle count covers all W+1 lines.
   always_comb begin
      diff_data        = '0;
      diff_data[W-1:0] = d_i ^ p_i[W-1:0];
      inv              = cfg_en_i && (popcount(diff_data) > W / 2);
      enc_o            = inv ? {1'b1, ~d_i} : {1'b0, d_i};
      diff_link        = '0;
      diff_link[W:0]   = enc_o ^ p_i;
      tog_o            = TW'(popcount(diff_link));
   end

endmodule

// File: rtl/businv_link_sched.sv
// Round-robin arbiter feeding one registered bus-invert link, with a
// saturating count of link bit transitions.
module businv_link_sched
   import businv_pkg::*;
#(
   parameter  int unsigned NREQ = NREQ_DEF,
   parameter  int unsigned W    = W_DEF,
   parameter  int unsigned CNTW = CNTW_DEF,
   localparam int unsigned GW   = $clog2(NREQ)
) (
   input  logic              ck,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   input  logic              bus_stall,
   input  logic              cfg_en,
   input  logic              cnt_clr,
   output logic [W:0]        bus_out,
   output logic              bus_valid,
   output logic [GW-1:0]     bus_gnt_id,
   output logic [CNTW-1:0]   toggle_cnt
);

   localparam int unsigned TW = $clog2(W + 2);

   logic [GW-1:0]   ptr_q, ptr_d;
   logic [GW-1:0]   gnt_idx;
   logic [NREQ-1:0] grant;
   logic            xfer;
   logic [W-1:0]    sel_data;
   logic [W:0]      enc;
   logic [TW-1:0]   tog;
   logic [W:0]      bus_out_q, bus_out_d;
   logic            bus_valid_q, bus_valid_d;
   logic [GW-1:0]   gnt_q, gnt_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [CNTW:0]   cnt_sum;

   // First valid requester at or above ptr, wrapping; gated by reset and stall.
   always_comb begin
      int unsigned idx;
      logic        found;
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      if (rst && !bus_stall) begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
               found      = 1'b1;
               grant[idx] = 1'b1;
               gnt_idx    = GW'(idx);
            end
         end
      end
   end

   assign req_ready = grant;
   assign xfer      = |grant;
   assign sel_data  = req_data[gnt_idx*W +: W];

   businv_encode #(
      .W  (W),
      .TW (TW)
   ) u_encode (
      .d_i      (sel_data),
      .p_i      (bus_out_q),
      .cfg_en_i (cfg_en),
      .enc_o    (enc),
      .tog_o    (tog)
   );

   always_comb begin
      bus_out_d   = bus_out_q;
      bus_valid_d = bus_valid_q;
      gnt_d       = gnt_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      cnt_sum     = {1'b0, cnt_q} + (CNTW+1)'(tog);
      if (xfer) begin
         bus_out_d   = enc;
         bus_valid_d = 1'b1;
         gnt_d       = gnt_idx;
         ptr_d       = (gnt_idx == GW'(NREQ - 1)) ? '0 : gnt_idx + GW'(1);
      end else if (!bus_stall) begin
         bus_valid_d = 1'b0;
      end
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (xfer) begin
         cnt_d = cnt_sum[CNTW] ? '1 : cnt_sum[CNTW-1:0];
      end
   end

   always_ff @(posedge ck) begin
      if (!rst) begin
         ptr_q       <= '0;
         bus_out_q   <= '0;
         bus_valid_q <= 1'b0;
         gnt_q       <= '0;
         cnt_q       <= '0;
      end else begin
         ptr_q       <= ptr_d;
         bus_out_q   <= bus_out_d;
         bus_valid_q <= bus_valid_d;
         gnt_q       <= gnt_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus_out    = bus_out_q;
   assign bus_valid  = bus_valid_q;
   assign bus_gnt_id = gnt_q;
   assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_businv_link_sched.sv
// Bench for businv_link_sched: directed scenarios plus random traffic,
// all compared against a transaction-level reference model.
module tb_businv_link_sched;
   import businv_pkg::*;

   localparam int unsigned NREQ = 4;
   localparam int unsigned W    = 8;
   localparam int unsigned CNTW = 16;
   localparam int unsigned CMAX = 65535;

   logic              ck = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              bus_stall;
   logic              cfg_en;
   logic              cnt_clr;
   logic [W:0]        bus_out;
   logic              bus_valid;
   logic [1:0]        bus_gnt_id;
   logic [CNTW-1:0]   toggle_cnt;

   always #5 ck = ~ck;

   businv_link_sched #(
      .NREQ (NREQ),
      .W    (W),
      .CNTW (CNTW)
   ) dut (
      .ck         (ck),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .bus_stall  (bus_stall),
      .cfg_en     (cfg_en),
      .cnt_clr    (cnt_clr),
      .bus_out    (bus_out),
      .bus_valid  (bus_valid),
      .bus_gnt_id (bus_gnt_id),
      .toggle_cnt (toggle_cnt)
   );

   int unsigned total  = 0;
   int unsigned passed = 0;

   // Reference model state
   int          m_ptr;
   link_t       m_bus;
   logic        m_valid;
   int          m_gnt;
   int unsigned m_cnt;
   logic [3:0]  exp_ready;
   int          exp_g;
   logic [7:0]  last_d;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
   endtask

   function automatic link_t ref_encode(input logic [7:0] d, input link_t prev, input logic en);
      link_t r;
      int    h;
      h = $countones(d ^ prev.data);
      if (en && h > int'(W / 2)) begin
         r.inv  = 1'b1;
         r.data = ~d;
      end else begin
         r.inv  = 1'b0;
         r.data = d;
      end
      return r;
   endfunction

   task automatic compute_ready();
      int i;
      exp_ready = '0;
      exp_g     = -1;
      if (rst && !bus_stall) begin
         for (int k = 0; k < int'(NREQ); k++) begin
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) begin
               exp_ready[i] = 1'b1;
               exp_g        = i;
               break;
            end
         end
      end
   endtask

   task automatic step();
      link_t       nb;
      int unsigned tog;
      logic        did_xfer;
      logic [7:0]  dec;
      @(negedge ck);
      compute_ready();
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      @(posedge ck);
      did_xfer = 1'b0;
      if (!rst) begin
         m_ptr = 0; m_bus = '0; m_valid = 1'b0; m_gnt = 0; m_cnt = 0;
      end else begin
         if (exp_g >= 0) begin
            did_xfer = 1'b1;
            last_d   = req_data[exp_g*W +: W];
            nb       = ref_encode(last_d, m_bus, cfg_en);
            tog      = $countones(nb ^ m_bus);
            m_bus    = nb;
            m_valid  = 1'b1;
            m_gnt    = exp_g;
            m_ptr    = (exp_g + 1) % NREQ;
            if (!cnt_clr) m_cnt = (m_cnt + tog > CMAX) ? CMAX : m_cnt + tog;
         end else if (!bus_stall) begin
            m_valid = 1'b0;
         end
         if (cnt_clr) m_cnt = 0;
      end
      #1;
      check("bus_out", 32'(bus_out), 32'(m_bus));
      check("bus_valid", 32'(bus_valid), 32'(m_valid));
      check("bus_gnt_id", 32'(bus_gnt_id), 32'(m_gnt));
      check("toggle_cnt", 32'(toggle_cnt), m_cnt);
      if (did_xfer) begin
         dec = bus_out[8] ? ~bus_out[7:0] : bus_out[7:0];
         check("decode", 32'(dec), 32'(last_d));
      end
   endtask

   task automatic send(input int r, input logic [7:0] d, input logic en, input logic clr);
      req_valid            = '0;
      req_valid[r]         = 1'b1;
      req_data[r*W +: W]   = d;
      cfg_en               = en;
      cnt_clr              = clr;
      bus_stall            = 1'b0;
      step();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; req_valid = '1; req_data = '0; bus_stall = 1'b0; cfg_en = 1'b0; cnt_clr = 1'b0;
      m_ptr = 0; m_bus = '0; m_valid = 1'b0; m_gnt = 0; m_cnt = 0; last_d = '0;
      repeat (2) step();
      check("rst_bus_out", 32'(bus_out), 32'h0);
      check("rst_cnt", 32'(toggle_cnt), 32'h0);

      // Bus-invert encoding from an all-zero link
      rst = 1'b1;
      send(0, 8'hFF, 1'b1, 1'b0);
      check("inv_ff", 32'(bus_out), 32'h100);
      check("inv_ff_cnt", 32'(toggle_cnt), 32'd1);
      send(0, 8'h0F, 1'b1, 1'b0);
      check("tie_0f", 32'(bus_out), 32'h00F);
      check("tie_0f_cnt", 32'(toggle_cnt), 32'd6);

      // Mid-stream reset
      req_valid = '1; rst = 1'b0;
      step();
      check("mid_rst_bus", 32'(bus_out), 32'h0);
      check("mid_rst_valid", 32'(bus_valid), 32'h0);
      check("mid_rst_cnt", 32'(toggle_cnt), 32'h0);

      // Plain transmission
      rst = 1'b1;
      send(0, 8'hFF, 1'b0, 1'b0);
      check("plain_ff", 32'(bus_out), 32'h0FF);
      send(0, 8'h0F, 1'b0, 1'b0);
      check("plain_0f", 32'(bus_out), 32'h00F);
      check("plain_cnt", 32'(toggle_cnt), 32'd12);

      // Round robin with everyone valid, pointer restarted by reset
      rst = 1'b0; step(); rst = 1'b1;
      req_valid = '1; cfg_en = 1'b1; cnt_clr = 1'b0; bus_stall = 1'b0;
      for (int i = 0; i < 5; i++) begin
         req_data = $urandom;
         step();
         check("rr_gnt", 32'(bus_gnt_id), 32'(i % 4));
         check("rr_valid", 32'(bus_valid), 32'h1);
      end

      // Stall with requesters valid: everything frozen
      bus_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_data = $urandom;
         step();
         check("stall_ready", 32'(req_ready), 32'h0);
         check("stall_valid", 32'(bus_valid), 32'h1);
         check("stall_gnt", 32'(bus_gnt_id), 32'h0);
      end
      bus_stall = 1'b0;
      step();
      check("resume_gnt", 32'(bus_gnt_id), 32'h1);

      // Counter saturation: 8190*8 + 12 + 2 = 0xFFFE, then a 9-toggle word
      rst = 1'b0; step(); rst = 1'b1;
      for (int i = 0; i < 8190; i++) send(0, (i % 2 == 0) ? 8'hFF : 8'h00, 1'b0, 1'b0);
      send(0, 8'h3F, 1'b0, 1'b0);
      send(0, 8'h00, 1'b0, 1'b0);
      check("pre_cnt", 32'(toggle_cnt), 32'd65532);
      send(0, 8'hFE, 1'b1, 1'b0);
      check("pre_bus", 32'(bus_out), 32'h101);
      check("cnt_fffe", 32'(toggle_cnt), 32'hFFFE);
      send(0, 8'hFE, 1'b0, 1'b0);
      check("nine_bus", 32'(bus_out), 32'h0FE);
      check("cnt_sat", 32'(toggle_cnt), 32'hFFFF);
      send(0, 8'h01, 1'b0, 1'b0);
      check("cnt_hold", 32'(toggle_cnt), 32'hFFFF);
      send(0, 8'hAA, 1'b0, 1'b1);
      check("cnt_clr_xfer", 32'(toggle_cnt), 32'h0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rst       = !($urandom_range(0, 49) == 0);
         req_valid = 4'($urandom_range(0, 15));
         req_data  = $urandom;
         bus_stall = ($urandom_range(0, 3) == 0);
         cfg_en    = ($urandom_range(0, 1) == 1);
         cnt_clr   = ($urandom_range(0, 19) == 0);
         step();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
